// File: rtl/rv_alu_pkg.sv
// Shared definitions for the rv_alu issue stage: operation codes, branch
// conditions, ALU command-vector bit positions and issue FSM states.
package rv_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_AND     = 4'd2,
    OP_OR      = 4'd3,
    OP_XOR     = 4'd4,
    OP_SLL     = 4'd5,
    OP_SRL     = 4'd6,
    OP_SRA     = 4'd7,
    OP_SLT     = 4'd8,
    OP_SLTU    = 4'd9,
    OP_MUL     = 4'd10,
    OP_MULH    = 4'd11,
    OP_MULHU   = 4'd12,
    OP_DIV     = 4'd13,
    OP_BR      = 4'd14,
    OP_ILLEGAL = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    BR_EQ   = 3'd0,
    BR_NE   = 3'd1,
    BR_RSV2 = 3'd2,
    BR_RSV3 = 3'd3,
    BR_LT   = 3'd4,
    BR_GE   = 3'd5,
    BR_LTU  = 3'd6,
    BR_GEU  = 3'd7
  } brcond_e;

  // Command vector, MSB first:
  // {signed, addsub, mul, div, div_mod, cmp, negate_op2, and, xor,
  //  shift, shift_right, mul_high, signed_b}; div_mod (bit 8) is never set here.
  localparam int CMD_W       = 13;
  localparam int CMD_SIGNED  = 12;
  localparam int CMD_ADDSUB  = 11;
  localparam int CMD_MUL     = 10;
  localparam int CMD_DIV     = 9;
  localparam int CMD_CMP     = 7;
  localparam int CMD_NEGATE  = 6;
  localparam int CMD_AND     = 5;
  localparam int CMD_XOR     = 4;
  localparam int CMD_SHIFT   = 3;
  localparam int CMD_RIGHT   = 2;
  localparam int CMD_MULHIGH = 1;
  localparam int CMD_SIGNEDB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CMP,
    S_RESP
  } state_e;

  // Branch decision from the derived compare relations; reserved codes never take.
  function automatic logic br_resolve(input logic [2:0] bc, input logic eq,
                                      input logic lt, input logic ltu);
    case (bc)
      BR_EQ:   return eq;
      BR_NE:   return ~eq;
      BR_LT:   return lt;
      BR_GE:   return ~lt;
      BR_LTU:  return ltu;
      BR_GEU:  return ~ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic br_reserved(input logic [2:0] bc);
    return (bc == BR_RSV2) || (bc == BR_RSV3);
  endfunction

endpackage

// File: rtl/rv_alu_op_decode.sv
// Combinational translation of a 4-bit op code into the rv_alu command vector.
module rv_alu_op_decode
  import rv_alu_pkg::*;
(
  input  logic [3:0]       op_i,
  output logic [CMD_W-1:0] cmd_o,
  output logic             illegal_o,
  output logic             is_cmp_o
);

  // Map each op to its command bits; compares carry no addsub so the ALU stays silent on we
  always_comb begin
    cmd_o     = '0;
    illegal_o = 1'b0;
    is_cmp_o  = 1'b0;
    case (op_i)
      OP_ADD:   cmd_o[CMD_ADDSUB] = 1'b1;
      OP_SUB: begin
        cmd_o[CMD_ADDSUB] = 1'b1;
        cmd_o[CMD_NEGATE] = 1'b1;
      end
      OP_AND:   cmd_o[CMD_AND] = 1'b1;
      OP_XOR:   cmd_o[CMD_XOR] = 1'b1;
      OP_OR: begin
        cmd_o[CMD_AND] = 1'b1;
        cmd_o[CMD_XOR] = 1'b1;
      end
      OP_SLL:   cmd_o[CMD_SHIFT] = 1'b1;
      OP_SRL: begin
        cmd_o[CMD_SHIFT] = 1'b1;
        cmd_o[CMD_RIGHT] = 1'b1;
      end
      OP_SRA: begin
        cmd_o[CMD_SHIFT]  = 1'b1;
        cmd_o[CMD_RIGHT]  = 1'b1;
        cmd_o[CMD_SIGNED] = 1'b1;
      end
      OP_MUL:   cmd_o[CMD_MUL] = 1'b1;
      OP_MULH: begin
        cmd_o[CMD_MUL]     = 1'b1;
        cmd_o[CMD_MULHIGH] = 1'b1;
        cmd_o[CMD_SIGNED]  = 1'b1;
        cmd_o[CMD_SIGNEDB] = 1'b1;
      end
      OP_MULHU: begin
        cmd_o[CMD_MUL]     = 1'b1;
        cmd_o[CMD_MULHIGH] = 1'b1;
      end
      OP_DIV:   cmd_o[CMD_DIV] = 1'b1;
      OP_SLT, OP_SLTU, OP_BR: begin
        cmd_o[CMD_CMP]    = 1'b1;
        cmd_o[CMD_NEGATE] = 1'b1;
        is_cmp_o          = 1'b1;
      end
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_alu_issue.sv
// Issue stage for rv_alu: accepts one decoded op, drives the ALU, waits out
// multi-cycle ops under a watchdog, resolves compares/branches and hands
// results to writeback.
module rv_alu_issue
  import rv_alu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dec_valid_i,
  output logic        dec_ready_o,
  input  logic [3:0]  dec_op_i,
  input  logic [2:0]  dec_brcond_i,
  input  logic [31:0] dec_op1_i,
  input  logic [31:0] dec_op2_i,
  input  logic [4:0]  dec_rd_i,
  output logic        alu_valid_o,
  output logic [12:0] alu_cmd_o,
  output logic [31:0] alu_op1_o,
  output logic [31:0] alu_op2_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_we_i,
  input  logic        alu_wait_i,
  input  logic        alu_busy_i,
  input  logic        alu_cmp_eq_i,
  input  logic        alu_cmp_ug_i,
  input  logic        alu_cmp_sg_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        br_valid_o,
  output logic        br_taken_o,
  output logic        err_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  op_e              op_q;
  logic [2:0]       brcond_q;
  logic [4:0]       rd_q;
  logic [31:0]      op1_q, op2_q, res_q, res_d;
  logic [CMD_W-1:0] cmd_q, dec_cmd;
  logic             is_cmp_q, dec_illegal, dec_is_cmp;
  logic             cap_dec, cap_res, br_valid, br_taken;
  logic             lt, ltu, alu_active;

  rv_alu_op_decode u_op_decode (
    .op_i      (dec_op_i),
    .cmd_o     (dec_cmd),
    .illegal_o (dec_illegal),
    .is_cmp_o  (dec_is_cmp)
  );

  assign lt  = ~alu_cmp_sg_i & ~alu_cmp_eq_i;
  assign ltu = ~alu_cmp_ug_i & ~alu_cmp_eq_i;

  // Next state, watchdog, result capture and branch strobe
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    cap_dec  = 1'b0;
    cap_res  = 1'b0;
    res_d    = res_q;
    br_valid = 1'b0;
    br_taken = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dec_valid_i) begin
          cap_dec = 1'b1;
          if (dec_illegal) err_d = 1'b1;
          else             state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (alu_we_i) begin
          cap_res = 1'b1;
          res_d   = alu_result_i;
          state_d = (rd_q == 5'd0) ? S_IDLE : S_RESP;
        end else if (is_cmp_q) begin
          state_d = S_CMP;
        end else if (alu_wait_i) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (alu_we_i) begin
          cap_res = 1'b1;
          res_d   = alu_result_i;
          state_d = (rd_q == 5'd0) ? S_IDLE : S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CMP: begin
        if (op_q == OP_BR) begin
          br_valid = 1'b1;
          br_taken = br_resolve(brcond_q, alu_cmp_eq_i, lt, ltu);
          err_d    = br_reserved(brcond_q);
          state_d  = S_IDLE;
        end else begin
          cap_res = 1'b1;
          res_d   = {31'b0, (op_q == OP_SLTU) ? ltu : lt};
          state_d = (rd_q == 5'd0) ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        if (wb_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Operation and result holding registers; outputs are gated by state
  always_ff @(posedge clk_i) begin
    if (cap_dec) begin
      op_q     <= op_e'(dec_op_i);
      brcond_q <= dec_brcond_i;
      rd_q     <= dec_rd_i;
      op1_q    <= dec_op1_i;
      op2_q    <= dec_op2_i;
      cmd_q    <= dec_cmd;
      is_cmp_q <= dec_is_cmp;
    end
    if (cap_res) res_q <= res_d;
  end

  assign alu_active  = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CMP);
  assign dec_ready_o = (state_q == S_IDLE) && !rst_i;
  assign alu_valid_o = (state_q == S_ISSUE);
  assign alu_cmd_o   = alu_active ? cmd_q : '0;
  assign alu_op1_o   = alu_active ? op1_q : '0;
  assign alu_op2_o   = alu_active ? op2_q : '0;
  assign wb_valid_o  = (state_q == S_RESP);
  assign wb_rd_o     = wb_valid_o ? rd_q : '0;
  assign wb_data_o   = wb_valid_o ? res_q : '0;
  assign br_valid_o  = br_valid;
  assign br_taken_o  = br_taken;
  assign err_o       = err_q;

  // A new command must only be launched into an idle ALU
  assert property (@(posedge clk_i) disable iff (rst_i) alu_valid_o |-> !alu_busy_i);

endmodule
